// File: rtl/turf_event_ctrl_pkg.sv
// rtl/turf_event_ctrl_pkg.sv - shared constants and types for the TURF event control UDP protocol
package turf_event_ctrl_pkg;

    // Command codes: two ASCII characters, first character in [15:8]
    localparam logic [15:0] CMD_OP = 16'h4F50;
    localparam logic [15:0] CMD_CL = 16'h434C;
    localparam logic [15:0] CMD_ID = 16'h4944;
    localparam logic [15:0] CMD_PR = 16'h5052;
    localparam logic [15:0] CMD_PW = 16'h5057;

    // Every control packet carries exactly one qword of payload
    localparam logic [15:0] CTRL_UDP_LEN = 16'd16;

    // UDP header word layout: {ip, port, length}
    localparam int HDR_IP_LSB   = 32;
    localparam int HDR_PORT_LSB = 16;
    localparam int HDR_LEN_LSB  = 0;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1
    } ctrl_status_e;

endpackage

// File: rtl/ctrl_timeout_ctr.sv
// rtl/ctrl_timeout_ctr.sv - saturating response timeout counter
//
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   clear         : restart the count at zero (has priority over enable)
//   enable        : advance the count by one this cycle
//   expired       : count has reached TIMEOUT_CYCLES-1; held until clear
module ctrl_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] TERMINAL = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Saturates at the terminal value so a timeout seen mid-packet is
    // remembered until the owner is able to act on it.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == TERMINAL);

endmodule

// File: rtl/turf_event_ctrl_initiator.sv
// rtl/turf_event_ctrl_initiator.sv - client-side initiator for TURF event control UDP commands
//
// Ports:
//   aclk, aresetn        : clock, synchronous active-low reset
//   cmd_*                : one command request (code, 48-bit arg, target ip/port)
//   rsp_valid/data/status: one-cycle completion pulse, response qword, 0=OK 1=TIMEOUT
//   busy                 : high whenever a transaction or drain is in progress
//   m_udphdr_*, m_udpdata_*: outbound UDP header and single-beat payload
//   s_udphdr_*, s_udpdata_*: inbound UDP header and payload beats
module turf_event_ctrl_initiator
    import turf_event_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 2,
    parameter     CHECK_SOURCE   = "TRUE"
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_code,
    input  logic [47:0] cmd_arg,
    input  logic [31:0] cmd_ip,
    input  logic [15:0] cmd_port,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic [63:0] m_udphdr_tdata,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,
    output logic [63:0] m_udpdata_tdata,
    output logic [7:0]  m_udpdata_tkeep,
    output logic        m_udpdata_tlast,
    output logic        m_udpdata_tvalid,
    input  logic        m_udpdata_tready,
    input  logic [63:0] s_udphdr_tdata,
    input  logic        s_udphdr_tvalid,
    output logic        s_udphdr_tready,
    input  logic [63:0] s_udpdata_tdata,
    input  logic [7:0]  s_udpdata_tkeep,
    input  logic        s_udpdata_tlast,
    input  logic        s_udpdata_tvalid,
    output logic        s_udpdata_tready
);

    localparam bit CHECK_SRC = (CHECK_SOURCE == "TRUE");

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_HDR,
        S_SEND_DATA,
        S_WAIT_HDR,
        S_READ_DATA,
        S_DRAIN_OK,
        S_DRAIN_W,
        S_DRAIN,
        S_DONE_OK,
        S_DONE_TO
    } state_t;

    state_t      state;
    state_t      to_state;
    logic [63:0] req;
    logic [31:0] tgt_ip;
    logic [15:0] tgt_port;
    logic [3:0]  retry_cnt;
    logic [3:0]  retry_inc;
    logic [63:0] rsp_word;
    logic        retry_ok;
    logic        to_expired;
    logic        src_ok;
    logic        rsp_match;

    // Inbound length field is not needed: payload extent is given by tlast
    logic unused_hdr_len;
    assign unused_hdr_len = &{1'b0, s_udphdr_tdata[HDR_LEN_LSB +: 16]};

    ctrl_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .aclk   (aclk),
        .aresetn(aresetn),
        .clear  (state == S_SEND_DATA && m_udpdata_tready),
        .enable (state == S_WAIT_HDR || state == S_READ_DATA || state == S_DRAIN_W),
        .expired(to_expired)
    );

    // Where a timeout leads: resend the identical packet or give up
    assign retry_ok  = (retry_cnt < 4'(MAX_RETRIES));
    assign retry_inc = {3'b000, retry_ok};
    assign to_state  = retry_ok ? S_SEND_HDR : S_DONE_TO;

    assign src_ok    = !CHECK_SRC ||
                       (s_udphdr_tdata[HDR_IP_LSB +: 32] == tgt_ip &&
                        s_udphdr_tdata[HDR_PORT_LSB +: 16] == tgt_port);
    // The tag lives in arg[47:32]; late replies to an earlier attempt carry
    // the same tag and are accepted.
    assign rsp_match = (s_udpdata_tkeep == 8'hFF) &&
                       (s_udpdata_tdata[63:48] == req[63:48]);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            req       <= '0;
            tgt_ip    <= '0;
            tgt_port  <= '0;
            retry_cnt <= '0;
            rsp_word  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Inbound traffic wins over a simultaneous command
                    if (s_udphdr_tvalid) begin
                        state <= S_DRAIN;
                    end else if (cmd_valid) begin
                        req       <= {cmd_arg, cmd_code};
                        tgt_ip    <= cmd_ip;
                        tgt_port  <= cmd_port;
                        retry_cnt <= '0;
                        state     <= S_SEND_HDR;
                    end
                end
                S_SEND_HDR: begin
                    if (m_udphdr_tready) state <= S_SEND_DATA;
                end
                S_SEND_DATA: begin
                    if (m_udpdata_tready) state <= S_WAIT_HDR;
                end
                S_WAIT_HDR: begin
                    // A header on the terminal cycle is still taken; the
                    // saturated timer is then acted on at its tlast.
                    if (s_udphdr_tvalid) begin
                        state <= src_ok ? S_READ_DATA : S_DRAIN_W;
                    end else if (to_expired) begin
                        state     <= to_state;
                        retry_cnt <= retry_cnt + retry_inc;
                    end
                end
                S_READ_DATA: begin
                    if (s_udpdata_tvalid) begin
                        if (rsp_match) begin
                            rsp_word <= s_udpdata_tdata;
                            state    <= s_udpdata_tlast ? S_DONE_OK : S_DRAIN_OK;
                        end else if (!s_udpdata_tlast) begin
                            state <= S_DRAIN_W;
                        end else if (to_expired) begin
                            state     <= to_state;
                            retry_cnt <= retry_cnt + retry_inc;
                        end else begin
                            state <= S_WAIT_HDR;
                        end
                    end
                end
                S_DRAIN_OK: begin
                    if (s_udpdata_tvalid && s_udpdata_tlast) state <= S_DONE_OK;
                end
                S_DRAIN_W: begin
                    if (s_udpdata_tvalid && s_udpdata_tlast) begin
                        if (to_expired) begin
                            state     <= to_state;
                            retry_cnt <= retry_cnt + retry_inc;
                        end else begin
                            state <= S_WAIT_HDR;
                        end
                    end
                end
                S_DRAIN: begin
                    if (s_udpdata_tvalid && s_udpdata_tlast) state <= S_IDLE;
                end
                S_DONE_OK, S_DONE_TO: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode the state register; nothing reaches them combinationally
    // from the inbound side except cmd_ready's inbound-priority gate.
    assign cmd_ready        = aresetn && (state == S_IDLE) && !s_udphdr_tvalid;
    assign busy             = (state != S_IDLE);
    assign rsp_valid        = (state == S_DONE_OK) || (state == S_DONE_TO);
    assign rsp_status       = (state == S_DONE_TO) ? ST_TIMEOUT : ST_OK;
    assign rsp_data         = (state == S_DONE_OK) ? rsp_word : 64'd0;

    assign m_udphdr_tvalid  = (state == S_SEND_HDR);
    assign m_udphdr_tdata   = {tgt_ip, tgt_port, CTRL_UDP_LEN};
    assign m_udpdata_tvalid = (state == S_SEND_DATA);
    assign m_udpdata_tdata  = req;
    assign m_udpdata_tkeep  = 8'hFF;
    assign m_udpdata_tlast  = 1'b1;

    assign s_udphdr_tready  = (state == S_IDLE) || (state == S_WAIT_HDR);
    assign s_udpdata_tready = (state == S_READ_DATA) || (state == S_DRAIN_OK) ||
                              (state == S_DRAIN_W)   || (state == S_DRAIN);

endmodule

// File: tb/tb_turf_event_ctrl_initiator.sv
// tb/tb_turf_event_ctrl_initiator.sv - randomized self-checking bench for turf_event_ctrl_initiator
module tb_turf_event_ctrl_initiator;

    localparam int TO = 100;
    localparam int MR = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_code = '0;
    logic [47:0] cmd_arg = '0;
    logic [31:0] cmd_ip = '0;
    logic [15:0] cmd_port = '0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [63:0] m_udphdr_tdata;
    logic        m_udphdr_tvalid;
    logic        m_udphdr_tready = 1'b1;
    logic [63:0] m_udpdata_tdata;
    logic [7:0]  m_udpdata_tkeep;
    logic        m_udpdata_tlast;
    logic        m_udpdata_tvalid;
    logic        m_udpdata_tready = 1'b1;
    logic [63:0] s_udphdr_tdata = '0;
    logic        s_udphdr_tvalid = 1'b0;
    logic        s_udphdr_tready;
    logic [63:0] s_udpdata_tdata = '0;
    logic [7:0]  s_udpdata_tkeep = '0;
    logic        s_udpdata_tlast = 1'b0;
    logic        s_udpdata_tvalid = 1'b0;
    logic        s_udpdata_tready;

    always #5 aclk = ~aclk;

    turf_event_ctrl_initiator #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MR),
        .CHECK_SOURCE  ("TRUE")
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_code        (cmd_code),
        .cmd_arg         (cmd_arg),
        .cmd_ip          (cmd_ip),
        .cmd_port        (cmd_port),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_status      (rsp_status),
        .busy            (busy),
        .m_udphdr_tdata  (m_udphdr_tdata),
        .m_udphdr_tvalid (m_udphdr_tvalid),
        .m_udphdr_tready (m_udphdr_tready),
        .m_udpdata_tdata (m_udpdata_tdata),
        .m_udpdata_tkeep (m_udpdata_tkeep),
        .m_udpdata_tlast (m_udpdata_tlast),
        .m_udpdata_tvalid(m_udpdata_tvalid),
        .m_udpdata_tready(m_udpdata_tready),
        .s_udphdr_tdata  (s_udphdr_tdata),
        .s_udphdr_tvalid (s_udphdr_tvalid),
        .s_udphdr_tready (s_udphdr_tready),
        .s_udpdata_tdata (s_udpdata_tdata),
        .s_udpdata_tkeep (s_udpdata_tkeep),
        .s_udpdata_tlast (s_udpdata_tlast),
        .s_udpdata_tvalid(s_udpdata_tvalid),
        .s_udpdata_tready(s_udpdata_tready)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [15:0] codes [5] = '{16'h4F50, 16'h434C, 16'h4944, 16'h5052, 16'h5057};

    // Observation queues, filled at the falling edge from handshakes that
    // complete on the following rising edge.
    int cyc = 0;
    logic [63:0] hdr_q[$];
    logic [63:0] dat_q[$];
    logic [8:0]  dat_kl[$];
    logic [63:0] rsp_q[$];
    logic [1:0]  st_q[$];
    int hdr_c[$], dat_c[$], rsp_c[$], acc_c[$], last_c[$];

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_udphdr_tvalid && m_udphdr_tready) begin
                hdr_q.push_back(m_udphdr_tdata);
                hdr_c.push_back(cyc);
            end
            if (m_udpdata_tvalid && m_udpdata_tready) begin
                dat_q.push_back(m_udpdata_tdata);
                dat_kl.push_back({m_udpdata_tkeep, m_udpdata_tlast});
                dat_c.push_back(cyc);
            end
            if (cmd_valid && cmd_ready) acc_c.push_back(cyc);
            if (s_udpdata_tvalid && s_udpdata_tready && s_udpdata_tlast) last_c.push_back(cyc);
        end
        if (rsp_valid) begin
            rsp_q.push_back(rsp_data);
            st_q.push_back(rsp_status);
            rsp_c.push_back(cyc);
        end
    end

    task automatic clear_q();
        hdr_q.delete(); dat_q.delete(); dat_kl.delete(); rsp_q.delete(); st_q.delete();
        hdr_c.delete(); dat_c.delete(); rsp_c.delete(); acc_c.delete(); last_c.delete();
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] code, input logic [47:0] arg,
                         input logic [31:0] ip, input logic [15:0] port);
        bit ok;
        int n;
        ok = 0;
        n = 0;
        cmd_valid = 1'b1; cmd_code = code; cmd_arg = arg; cmd_ip = ip; cmd_port = port;
        do begin
            @(negedge aclk);
            ok = cmd_ready;
            @(posedge aclk);
            #1;
            n++;
        end while (!ok && n < 400);
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_bound", 0, 1);
    endtask

    task automatic send_pkt(input logic [31:0] ip, input logic [15:0] port, input int nbeats,
                            input logic [63:0] beat0, input logic [7:0] keep0);
        bit ok;
        int n;
        ok = 0;
        n = 0;
        s_udphdr_tvalid = 1'b1;
        s_udphdr_tdata  = {ip, port, 16'd16};
        do begin
            @(negedge aclk);
            ok = s_udphdr_tready;
            @(posedge aclk);
            #1;
            n++;
        end while (!ok && n < 200);
        s_udphdr_tvalid = 1'b0;
        if (!ok) check("in_hdr_bound", 0, 1);
        for (int i = 0; i < nbeats; i++) begin
            s_udpdata_tvalid = 1'b1;
            s_udpdata_tdata  = (i == 0) ? beat0 : {$urandom(), $urandom()};
            s_udpdata_tkeep  = (i == 0) ? keep0 : 8'hFF;
            s_udpdata_tlast  = (i == nbeats - 1);
            ok = 0;
            n = 0;
            do begin
                @(negedge aclk);
                ok = s_udpdata_tready;
                @(posedge aclk);
                #1;
                n++;
            end while (!ok && n < 200);
            if (!ok) check("in_data_bound", 0, 1);
        end
        s_udpdata_tvalid = 1'b0;
        s_udpdata_tlast  = 1'b0;
    endtask

    task automatic wait_dat(input int want, input int bound);
        int n;
        n = 0;
        while (dat_q.size() < want && n < bound) begin
            @(negedge aclk);
            n++;
        end
        check("out_pkt_arrived", 64'(dat_q.size() >= want), 1);
        tick();
    endtask

    task automatic wait_rsp(input int want, input int bound);
        int n;
        n = 0;
        while (rsp_q.size() < want && n < bound) begin
            @(negedge aclk);
            n++;
        end
        check("rsp_arrived", 64'(rsp_q.size() >= want), 1);
        tick();
    endtask

    // Outbound packet i must be {ip, port, 16} followed by {arg, code}, tkeep=FF, tlast=1
    task automatic check_out(input int i, input logic [31:0] ip, input logic [15:0] port,
                             input logic [63:0] req);
        if (hdr_q.size() > i && dat_q.size() > i) begin
            check("out_hdr", hdr_q[i], {ip, port, 16'd16});
            check("out_payload", dat_q[i], req);
            check("out_keep_last", 64'(dat_kl[i]), 64'h1FF);
        end else begin
            check("out_pkt_present", 0, 1);
        end
    endtask

    // kind 0: good reply; 1: wrong source first; 2: wrong tag/keep first; 3: silence
    task automatic run_txn(input int kind, input int nb);
        logic [15:0] code;
        logic [47:0] arg;
        logic [31:0] ip;
        logic [15:0] port;
        logic [63:0] req, good0, junk0;
        code = codes[$urandom_range(0, 4)];
        arg  = {16'($urandom()), 32'($urandom())};
        ip   = $urandom();
        port = 16'($urandom());
        req  = {arg, code};
        good0 = {arg[47:32], 16'($urandom()), 32'($urandom())};
        junk0 = {arg[47:32], 16'($urandom()), 32'($urandom())};
        clear_q();
        issue(code, arg, ip, port);
        wait_dat(1, 20);
        check_out(0, ip, port, req);
        case (kind)
            0: begin
                tick($urandom_range(0, 30));
                send_pkt(ip, port, nb, good0, 8'hFF);
            end
            1: begin
                if ($urandom_range(0, 1) == 1) send_pkt(ip ^ 32'h1, port, 1, junk0, 8'hFF);
                else send_pkt(ip, port ^ 16'h8000, 2, junk0, 8'hFF);
                send_pkt(ip, port, nb, good0, 8'hFF);
            end
            2: begin
                if ($urandom_range(0, 1) == 1)
                    send_pkt(ip, port, $urandom_range(1, 2), {arg[47:32] ^ 16'h0100, junk0[47:0]}, 8'hFF);
                else
                    send_pkt(ip, port, 1, junk0, 8'h0F);
                send_pkt(ip, port, nb, good0, 8'hFF);
            end
            default: ;
        endcase
        if (kind == 3) begin
            wait_rsp(1, 3 * (TO + 10));
            tick(3);
            check("to_hdr_count", 64'(hdr_q.size()), 3);
            check("to_dat_count", 64'(dat_q.size()), 3);
            for (int i = 0; i < 3; i++) check_out(i, ip, port, req);
            if (hdr_q.size() == 3 && dat_q.size() == 3) begin
                check("to_wait_gap1", 64'(hdr_c[1] - dat_c[0] - 1), TO);
                check("to_wait_gap2", 64'(hdr_c[2] - dat_c[1] - 1), TO);
                if (rsp_q.size() > 0) check("to_rsp_gap", 64'(rsp_c[0] - dat_c[2]), TO + 1);
            end
            check("to_rsp_count", 64'(rsp_q.size()), 1);
            if (rsp_q.size() > 0) begin
                check("to_status", 64'(st_q[0]), 1);
                check("to_data", rsp_q[0], 0);
            end
        end else begin
            wait_rsp(1, 60);
            tick(3);
            check("ok_rsp_count", 64'(rsp_q.size()), 1);
            check("ok_hdr_count", 64'(hdr_q.size()), 1);
            if (rsp_q.size() > 0) begin
                check("ok_data", rsp_q[0], good0);
                check("ok_status", 64'(st_q[0]), 0);
                if (last_c.size() > 0)
                    check("ok_latency", 64'(rsp_c[0] - last_c[last_c.size() - 1]), 1);
            end
        end
    endtask

    initial begin
        // Reset state
        cmd_valid = 1'b1;
        tick(3);
        @(negedge aclk);
        check("rst_cmd_ready", 64'(cmd_ready), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", 64'(rsp_status), 0);
        check("rst_m_hdr_tvalid", 64'(m_udphdr_tvalid), 0);
        check("rst_m_dat_tvalid", 64'(m_udpdata_tvalid), 0);
        check("rst_busy", 64'(busy), 0);
        tick();
        cmd_valid = 1'b0;
        aresetn = 1'b1;
        tick(2);

        // Directed "ID" to 10.0.0.2:21603
        clear_q();
        issue(16'h4944, 48'h1234_0000_0000, 32'h0A00_0002, 16'd21603);
        wait_dat(1, 20);
        if (hdr_q.size() > 0 && dat_q.size() > 0 && acc_c.size() > 0) begin
            check("id_hdr", hdr_q[0], 64'h0A000002_5463_0010);
            check("id_payload", dat_q[0], 64'h1234_0000_0000_4944);
            check("id_hdr_latency", 64'(hdr_c[0] - acc_c[0]), 1);
            check("id_dat_latency", 64'(dat_c[0] - hdr_c[0]), 1);
        end else begin
            check("id_out_present", 0, 1);
        end
        send_pkt(32'h0A00_0002, 16'd21603, 1, 64'h1234_AABB_CCDD_EEFF, 8'hFF);
        wait_rsp(1, 20);
        tick(2);
        check("id_rsp_count", 64'(rsp_q.size()), 1);
        if (rsp_q.size() > 0 && last_c.size() > 0) begin
            check("id_rsp_data", rsp_q[0], 64'h1234_AABB_CCDD_EEFF);
            check("id_rsp_status", 64'(st_q[0]), 0);
            check("id_rsp_latency", 64'(rsp_c[0] - last_c[0]), 1);
        end

        // Directed kinds: 3-beat reply, junk sources, junk tag, timeout with retries
        run_txn(0, 3);
        run_txn(1, 1);
        run_txn(2, 2);
        run_txn(3, 1);

        // Unsolicited packet while IDLE with a command pending
        clear_q();
        fork
            send_pkt(32'hC0A8_0101, 16'd5000, 3, 64'h0123_4567_89AB_CDEF, 8'hFF);
            issue(16'h4F50, 48'h4242_0000_0001, 32'h0A00_0009, 16'd1234);
        join
        wait_dat(1, 20);
        check("unsol_rsp_none", 64'(rsp_q.size()), 0);
        if (acc_c.size() > 0 && last_c.size() > 0 && hdr_c.size() > 0) begin
            check("unsol_accept_after_drain", 64'(acc_c[0] - last_c[0]), 1);
            check("unsol_hdr_latency", 64'(hdr_c[0] - acc_c[0]), 1);
        end else begin
            check("unsol_events_present", 0, 1);
        end
        check_out(0, 32'h0A00_0009, 16'd1234, 64'h4242_0000_0001_4F50);
        send_pkt(32'h0A00_0009, 16'd1234, 1, 64'h4242_0000_0000_0077, 8'hFF);
        wait_rsp(1, 20);
        if (rsp_q.size() > 0) check("unsol_op_rsp", rsp_q[0], 64'h4242_0000_0000_0077);

        // Header backpressure followed by reset mid-transaction
        clear_q();
        m_udphdr_tready = 1'b0;
        issue(16'h5057, 48'h0055_0000_0000, 32'h0A00_0001, 16'd77);
        tick(50);
        @(negedge aclk);
        check("bp_hdr_tvalid", 64'(m_udphdr_tvalid), 1);
        check("bp_busy", 64'(busy), 1);
        tick();
        aresetn = 1'b0;
        @(negedge aclk);
        check("bp_rst_cmd_ready", 64'(cmd_ready), 0);
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        check("bp_post_rst_tvalid", 64'(m_udphdr_tvalid), 0);
        check("bp_post_rst_busy", 64'(busy), 0);
        tick();
        m_udphdr_tready = 1'b1;
        tick(20);
        check("bp_no_hdr", 64'(hdr_q.size()), 0);
        check("bp_no_rsp", 64'(rsp_q.size()), 0);

        // Randomized transactions
        for (int t = 0; t < 8; t++) run_txn($urandom_range(0, 3), $urandom_range(1, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "bench time limit");
    end

endmodule
